instr_encoder: RTL

- Produces the 32-bit RV64I machine words that the control unit later decodes: ADD, SUB, AND, OR, LD, SD and BEQ.
- Accepts operation requests over a valid/ready handshake and encodes each one.
- Buffers encoded words in a small FIFO, then drains them into instruction memory through a sequential write-address counter.
- Serves as the program loader feeding the datapath's instruction memory.

---
 rtl/instr_encoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Program loader for the datapath's instruction memory. It accepts operation
// requests over a valid/ready handshake and encodes each one into a 32-bit
// RV64I word (ADD, SUB, AND, OR, LD, SD, BEQ). Encoded words are queued in a
// small FIFO and drained into instruction memory at sequential byte addresses.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   restart           : synchronous flush (FIFO, address, wr_count, err)
//   req_valid/ready   : request handshake; req_ready = FIFO not full
//   req_op            : 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LD, 5 SD, 6 BEQ, 7 illegal
//   req_rd/rs1/rs2    : register fields
//   req_imm           : LD/SD imm[11:0], BEQ offset[12:1]
//   imem_busy         : memory cannot accept a write this cycle
//   imem_we/addr/wdata: registered write port, one strobe per word
//   wr_count          : saturating count of words written
//   err               : sticky, set when an illegal op is accepted
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [11:0]       req_imm,
  input  logic              imem_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [15:0]       wr_count,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]    EMPTY_CNT = (PTR_W+1)'(0);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(4);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_LD  = 3'd4, OP_SD  = 3'd5, OP_BEQ = 3'd6, OP_ILL = 3'd7
  } op_e;

  // Builds the machine word for one request; illegal ops yield zero and are never pushed.
  function automatic logic [31:0] encode_instr(
    input logic [2:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [12:0] b;
    logic [31:0] w;
    b = {imm, 1'b0};  // branch offset is in half-words, bit 0 implicitly zero
    w = 32'h0000_0000;
    case (op_e'(op))
      OP_ADD:  w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_SUB:  w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_AND:  w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      OP_OR:   w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      OP_LD:   w = {imm, rs1, 3'b011, rd, 7'b0000011};
      OP_SD:   w = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      OP_BEQ:  w = {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], 7'b1100011};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [ADDR_W-1:0] addr_cnt_r;

  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] word_s;

  assign req_ready = (count_r != FULL_CNT);

  // Handshake qualification; restart overrides both push and pop.
  always_comb begin
    accept_s = req_valid && req_ready && !restart;
    push_s   = accept_s && (req_op != 3'd7);
    pop_s    = !restart && (count_r != EMPTY_CNT) && !imem_busy;
    word_s   = encode_instr(req_op, req_rd, req_rs1, req_rs2, req_imm);
  end

  // FIFO storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= EMPTY_CNT;
    end else if (restart) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= EMPTY_CNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain port: registered write strobe, address counter and write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 32'h0000_0000;
      addr_cnt_r <= BASE;
      wr_count   <= 16'h0000;
    end else if (restart) begin
      imem_we    <= 1'b0;
      addr_cnt_r <= BASE;
      wr_count   <= 16'h0000;
    end else if (pop_s) begin
      imem_we    <= 1'b1;
      imem_addr  <= addr_cnt_r;
      imem_wdata <= mem_r[rd_ptr_r];
      addr_cnt_r <= addr_cnt_r + STEP;  // wraps modulo 2^ADDR_W
      wr_count   <= (wr_count == 16'hFFFF) ? wr_count : wr_count + 16'h0001;
    end else begin
      imem_we    <= 1'b0;
    end
  end

  // Sticky illegal-op flag, cleared only by reset or restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (restart) begin
      err <= 1'b0;
    end else if (accept_s && (req_op == 3'd7)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

endmodule
